// File: rtl/mbist_response_comparator.sv
// mbist_response_comparator
//   Receive side of the MBIST engine. Samples the generator's port-A read
//   stream, delays address and expected data to line up with the RAM read
//   latency, compares against the RAM output and reports the outcome to the
//   BIST controller.
//
//   Optional feature: define MBIST_CMP_DIAG_EN to accumulate the OR of all
//   miscompare syndromes on cp_fail_bitmap. Otherwise cp_fail_bitmap is 0.
//
// Ports
//   cp_clk, cp_rst_n  clock, asynchronous active-low reset
//   cp_en             enable; low stops new launches, pipeline keeps draining
//   cp_clr            synchronous clear of results, pipeline and FSM
//   cp_cap            capture enable from generator
//   cp_check_ce       check enable from generator
//   cp_we             generator write enable (0 = read)
//   cp_addr, cp_exp   generator address and expected read data
//   cp_dout           RAM read data, RD_LAT cycles after the address
//   cp_ag_done        generator done level
//   cp_fail           sticky fail flag
//   cp_fail_pulse     one-cycle pulse per miscompare
//   cp_fail_addr      address of first miscompare
//   cp_fail_cnt       saturating miscompare count
//   cp_fail_bitmap    OR of miscompare syndromes (diagnostic build only)
//   cp_done, cp_pass  results final / no miscompare seen
module mbist_response_comparator #(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DATA_W = 36,
    parameter int unsigned RD_LAT = 1,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              cp_clk,
    input  logic              cp_rst_n,
    input  logic              cp_en,
    input  logic              cp_clr,
    input  logic              cp_cap,
    input  logic              cp_check_ce,
    input  logic              cp_we,
    input  logic [ADDR_W-1:0] cp_addr,
    input  logic [DATA_W-1:0] cp_exp,
    input  logic [DATA_W-1:0] cp_dout,
    input  logic              cp_ag_done,
    output logic              cp_fail,
    output logic              cp_fail_pulse,
    output logic [ADDR_W-1:0] cp_fail_addr,
    output logic [CNT_W-1:0]  cp_fail_cnt,
    output logic [DATA_W-1:0] cp_fail_bitmap,
    output logic              cp_done,
    output logic              cp_pass
);

    localparam int unsigned DRN_W = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARMED,
        ST_CHECK,
        ST_DRAIN,
        ST_DONE
    } state_e;

    state_e             state_q, state_d;
    logic [DRN_W-1:0]   drn_q, drn_d;
    logic               fail_q, fail_d;
    logic               pulse_q, pulse_d;
    logic [ADDR_W-1:0]  fail_addr_q, fail_addr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               done_q, done_d;
    logic               pass_q, pass_d;

    logic [RD_LAT-1:0]  vld_q;
    logic [ADDR_W-1:0]  addr_q [RD_LAT];
    logic [DATA_W-1:0]  exp_q  [RD_LAT];

    logic               sample;
    logic [DATA_W-1:0]  syn;
    logic               miscmp;

    // Launch a compare only for enabled read cycles while the test is running.
    assign sample = cp_en & cp_cap & cp_check_ce & ~cp_we &
                    ((state_q == ST_ARMED) | (state_q == ST_CHECK));

    // Oldest pipeline stage meets the RAM data of the same read.
    assign syn    = cp_dout ^ exp_q[RD_LAT-1];
    assign miscmp = vld_q[RD_LAT-1] & (|syn);

    // Address/expected-data delay line; only the valid bits need reset.
    always_ff @(posedge cp_clk) begin
        addr_q[0] <= cp_addr;
        exp_q[0]  <= cp_exp;
        for (int i = RD_LAT - 1; i > 0; i--) begin
            addr_q[i] <= addr_q[i-1];
            exp_q[i]  <= exp_q[i-1];
        end
    end

    // Next-state and result update; clear overrides everything.
    always_comb begin
        state_d     = state_q;
        drn_d       = drn_q;
        fail_d      = fail_q;
        pulse_d     = 1'b0;
        fail_addr_d = fail_addr_q;
        cnt_d       = cnt_q;

        if (miscmp) begin
            fail_d  = 1'b1;
            pulse_d = 1'b1;
            if (!fail_q) begin
                fail_addr_d = addr_q[RD_LAT-1];
            end
            if (cnt_q != {CNT_W{1'b1}}) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end

        // FSM is frozen while disabled; in-flight compares still complete.
        if (cp_en) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (cp_cap) state_d = ST_ARMED;
                end
                ST_ARMED, ST_CHECK: begin
                    if (cp_ag_done) begin
                        state_d = ST_DRAIN;
                        drn_d   = '0;
                    end else if (sample) begin
                        state_d = ST_CHECK;
                    end
                end
                // RD_LAT+1 cycles covers the last launched read.
                ST_DRAIN: begin
                    if (drn_q == DRN_W'(RD_LAT)) state_d = ST_DONE;
                    else                         drn_d   = drn_q + DRN_W'(1);
                end
                ST_DONE: begin
                    state_d = ST_DONE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        done_d = (state_d == ST_DONE);
        pass_d = done_d & ~fail_d;

        if (cp_clr) begin
            state_d     = ST_IDLE;
            drn_d       = '0;
            fail_d      = 1'b0;
            pulse_d     = 1'b0;
            fail_addr_d = '0;
            cnt_d       = '0;
            done_d      = 1'b0;
            pass_d      = 1'b0;
        end
    end

    // State, results and pipeline valids.
    always_ff @(posedge cp_clk or negedge cp_rst_n) begin
        if (!cp_rst_n) begin
            state_q     <= ST_IDLE;
            drn_q       <= '0;
            fail_q      <= 1'b0;
            pulse_q     <= 1'b0;
            fail_addr_q <= '0;
            cnt_q       <= '0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            vld_q       <= '0;
        end else begin
            state_q     <= state_d;
            drn_q       <= drn_d;
            fail_q      <= fail_d;
            pulse_q     <= pulse_d;
            fail_addr_q <= fail_addr_d;
            cnt_q       <= cnt_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            vld_q[0]    <= sample & ~cp_clr;
            for (int i = RD_LAT - 1; i > 0; i--) begin
                vld_q[i] <= vld_q[i-1] & ~cp_clr;
            end
        end
    end

`ifdef MBIST_CMP_DIAG_EN
    logic [DATA_W-1:0] bmp_q, bmp_d;

    // Per-column accumulation of failing bits.
    always_comb begin
        bmp_d = bmp_q;
        if (miscmp) bmp_d = bmp_q | syn;
        if (cp_clr) bmp_d = '0;
    end

    always_ff @(posedge cp_clk or negedge cp_rst_n) begin
        if (!cp_rst_n) bmp_q <= '0;
        else           bmp_q <= bmp_d;
    end

    assign cp_fail_bitmap = bmp_q;
`else
    assign cp_fail_bitmap = '0;
`endif

    assign cp_fail       = fail_q;
    assign cp_fail_pulse = pulse_q;
    assign cp_fail_addr  = fail_addr_q;
    assign cp_fail_cnt   = cnt_q;
    assign cp_done       = done_q;
    assign cp_pass       = pass_q;

endmodule

// File: tb/tb_mbist_response_comparator.sv
// Bench for mbist_response_comparator. Instance A: RD_LAT=1, CNT_W=16.
// Instance B: RD_LAT=3, CNT_W=2. Both use ADDR_W=2, DATA_W=36.
// Stimulus pushes expected pulse/done records into per-instance queues; a
// monitor process pops and compares whenever an instance shows an event.
module tb_mbist_response_comparator;

    localparam logic [35:0] CB0 = 36'h555555555;
    localparam logic [35:0] CB1 = 36'hAAAAAAAAA;
`ifdef MBIST_CMP_DIAG_EN
    localparam bit DIAG = 1'b1;
`else
    localparam bit DIAG = 1'b0;
`endif

    typedef struct {
        int         cyc;
        logic [1:0] addr;
        int         cnt;
    } pulse_t;

    typedef struct {
        int          cyc;
        bit          pass;
        int          cnt;
        logic [1:0]  addr;
        logic [35:0] bmp;
    } done_t;

    logic        clk = 1'b0;
    logic        rst_n, en, sel, clr, cap, ce, we, ag_done;
    logic [1:0]  addr;
    logic [35:0] expd, flip;
    logic        en_a, en_b;
    logic [35:0] dly_a;
    logic [35:0] dly_b [3];

    logic        a_fail, a_pulse, a_done, a_pass;
    logic [1:0]  a_faddr;
    logic [15:0] a_cnt;
    logic [35:0] a_bmp;
    logic        b_fail, b_pulse, b_done, b_pass;
    logic [1:0]  b_faddr;
    logic [1:0]  b_cnt;
    logic [35:0] b_bmp;

    int cyc_n = 0;
    int n_chk = 0;
    int n_pass = 0;

    pulse_t pq_a[$], pq_b[$];
    done_t  dq_a[$], dq_b[$];

    int m_fail [2];
    int m_first[2];
    int m_cnt  [2];
    bit          h_pass;
    int          h_cnt;
    int          h_addr;
    logic [35:0] h_bmp;

    always #5 clk = ~clk;
    always @(posedge clk) cyc_n <= cyc_n + 1;

    assign en_a = en & ~sel;
    assign en_b = en & sel;

    // RAM model: returns the (possibly corrupted) word RD_LAT cycles later.
    always @(posedge clk) begin
        dly_a    <= expd ^ flip;
        dly_b[0] <= expd ^ flip;
        dly_b[1] <= dly_b[0];
        dly_b[2] <= dly_b[1];
    end

    mbist_response_comparator #(.ADDR_W(2), .DATA_W(36), .RD_LAT(1), .CNT_W(16)) u_a (
        .cp_clk(clk), .cp_rst_n(rst_n), .cp_en(en_a), .cp_clr(clr), .cp_cap(cap),
        .cp_check_ce(ce), .cp_we(we), .cp_addr(addr), .cp_exp(expd), .cp_dout(dly_a),
        .cp_ag_done(ag_done), .cp_fail(a_fail), .cp_fail_pulse(a_pulse),
        .cp_fail_addr(a_faddr), .cp_fail_cnt(a_cnt), .cp_fail_bitmap(a_bmp),
        .cp_done(a_done), .cp_pass(a_pass));

    mbist_response_comparator #(.ADDR_W(2), .DATA_W(36), .RD_LAT(3), .CNT_W(2)) u_b (
        .cp_clk(clk), .cp_rst_n(rst_n), .cp_en(en_b), .cp_clr(clr), .cp_cap(cap),
        .cp_check_ce(ce), .cp_we(we), .cp_addr(addr), .cp_exp(expd), .cp_dout(dly_b[2]),
        .cp_ag_done(ag_done), .cp_fail(b_fail), .cp_fail_pulse(b_pulse),
        .cp_fail_addr(b_faddr), .cp_fail_cnt(b_cnt), .cp_fail_bitmap(b_bmp),
        .cp_done(b_done), .cp_pass(b_pass));

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, req, cyc_n);
    endtask

    task automatic chk_zero(input string nm, input bit inst);
        logic [63:0] v;
        if (inst) v = 64'({b_fail, b_pulse, b_faddr, 16'(b_cnt), b_bmp, b_done, b_pass});
        else      v = 64'({a_fail, a_pulse, a_faddr, a_cnt, a_bmp, a_done, a_pass});
        chk(nm, v, 64'd0);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_fail[i] = 0; m_first[i] = 0; m_cnt[i] = 0;
        end
    endtask

    task automatic expect_done(input bit p, input int c, input int a, input logic [35:0] b);
        h_pass = p; h_cnt = c; h_addr = a; h_bmp = DIAG ? b : 36'h0;
    endtask

    // One generator cycle; cmp marks a read the comparator must check.
    task automatic step(input bit c, input bit chk_en, input bit w, input int a,
                        input logic [35:0] f, input bit dn, input bit cmp);
        int     lat;
        int     mx;
        pulse_t p;
        done_t  d;
        lat = sel ? 3 : 1;
        mx  = sel ? 3 : 65535;
        cap = c; ce = chk_en; we = w; addr = 2'(a);
        expd = (a % 2 == 1) ? CB1 : CB0;
        flip = f; ag_done = dn;
        if (cmp && f != 36'h0) begin
            if (m_fail[sel] == 0) m_first[sel] = a;
            m_fail[sel] = 1;
            if (m_cnt[sel] < mx) m_cnt[sel]++;
            p.cyc = cyc_n + 1 + lat; p.addr = 2'(m_first[sel]); p.cnt = m_cnt[sel];
            if (sel) pq_b.push_back(p); else pq_a.push_back(p);
        end
        if (dn) begin
            d.cyc = cyc_n + 2 + lat; d.pass = h_pass; d.cnt = h_cnt;
            d.addr = 2'(h_addr); d.bmp = h_bmp;
            if (sel) dq_b.push_back(d); else dq_a.push_back(d);
        end
        @(posedge clk); #1;
        ag_done = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 36'h0, 0, 0);
    endtask

    task automatic writes(input logic [35:0] f);
        for (int a = 0; a < 4; a++) step(1, 1, 1, a, f, 0, 0);
    endtask

    task automatic do_clr(input string nm);
        clr = 1'b1;
        idle(1);
        clr = 1'b0;
        model_reset();
        chk_zero(nm, sel);
    endtask

    task automatic mon(input bit inst, input bit prev_done, output bit now_done);
        logic        pl, fl, dn, ps;
        logic [1:0]  fa;
        int          cn;
        logic [35:0] bm;
        string       t;
        pulse_t      p;
        done_t       d;
        bit          empty;
        t  = inst ? "B" : "A";
        pl = inst ? b_pulse : a_pulse;
        fl = inst ? b_fail  : a_fail;
        dn = inst ? b_done  : a_done;
        ps = inst ? b_pass  : a_pass;
        fa = inst ? b_faddr : a_faddr;
        cn = inst ? int'(b_cnt) : int'(a_cnt);
        bm = inst ? b_bmp   : a_bmp;
        if (pl) begin
            empty = inst ? (pq_b.size() == 0) : (pq_a.size() == 0);
            if (empty) begin
                n_chk++;
                $display("FAIL %s_pulse_unexpected: pulse at cycle %0d, none expected", t, cyc_n);
            end else begin
                if (inst) p = pq_b.pop_front(); else p = pq_a.pop_front();
                chk({t, "_pulse_cycle"}, 64'(cyc_n), 64'(p.cyc));
                chk({t, "_pulse_fail_addr"}, 64'(fa), 64'(p.addr));
                chk({t, "_pulse_fail_cnt"}, 64'(cn), 64'(p.cnt));
                chk({t, "_pulse_fail_flag"}, 64'(fl), 64'd1);
            end
        end
        if (dn && !prev_done) begin
            empty = inst ? (dq_b.size() == 0) : (dq_a.size() == 0);
            if (empty) begin
                n_chk++;
                $display("FAIL %s_done_unexpected: done at cycle %0d, none expected", t, cyc_n);
            end else begin
                if (inst) d = dq_b.pop_front(); else d = dq_a.pop_front();
                chk({t, "_done_cycle"}, 64'(cyc_n), 64'(d.cyc));
                chk({t, "_done_pass"}, 64'(ps), 64'(d.pass));
                chk({t, "_done_fail"}, 64'(fl), 64'(!d.pass));
                chk({t, "_done_cnt"}, 64'(cn), 64'(d.cnt));
                chk({t, "_done_fail_addr"}, 64'(fa), 64'(d.addr));
                chk({t, "_done_bitmap"}, 64'(bm), 64'(d.bmp));
            end
        end
        now_done = dn;
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; sel = 1'b0; clr = 1'b0; cap = 1'b0; ce = 1'b0;
        we = 1'b0; addr = 2'd0; expd = 36'h0; flip = 36'h0; ag_done = 1'b0;
        model_reset();
        expect_done(1, 0, 0, 36'h0);

        fork
            begin : monitor
                bit pa, pb, na, nb;
                pa = 1'b0; pb = 1'b0;
                forever begin
                    @(negedge clk);
                    if (rst_n) begin
                        mon(1'b0, pa, na);
                        mon(1'b1, pb, nb);
                        pa = na; pb = nb;
                    end else begin
                        pa = 1'b0; pb = 1'b0;
                    end
                end
            end
        join_none

        repeat (2) @(posedge clk);
        #1;
        chk_zero("A_reset_state", 1'b0);
        chk_zero("B_reset_state", 1'b1);
        rst_n = 1'b1; en = 1'b1;
        @(posedge clk); #1;

        // Fault-free checkerboard on A.
        sel = 1'b0;
        writes(36'h0);
        for (int a = 0; a < 4; a++) step(1, 1, 0, a, 36'h0, 0, 1);
        expect_done(1, 0, 0, 36'h0);
        step(0, 0, 0, 0, 36'h0, 1, 0);
        idle(4);
        do_clr("A_clr_after_t1");

        // Single stuck bit at address 2.
        writes(36'h0);
        for (int a = 0; a < 4; a++) step(1, 1, 0, a, (a == 2) ? 36'h1 : 36'h0, 0, 1);
        expect_done(0, 1, 2, 36'h1);
        step(0, 0, 0, 0, 36'h0, 1, 0);
        idle(4);
        do_clr("A_clr_after_t2");

        // Faults at 1 then 3; corrupted write cycles and check_ce=0 reads ignored.
        writes(36'hFFFF00000);
        step(1, 0, 0, 0, 36'h3, 0, 0);
        step(1, 1, 0, 1, 36'h4, 0, 1);
        step(1, 1, 0, 2, 36'h0, 0, 1);
        step(1, 1, 0, 3, 36'h800000000, 0, 1);
        expect_done(0, 2, 1, 36'h800000004);
        step(0, 0, 0, 0, 36'h0, 1, 0);
        idle(4);
        do_clr("A_clr_after_t3");

        // B: RD_LAT=3, done raised on the cycle of the last (faulty) read.
        sel = 1'b1;
        writes(36'h0);
        for (int a = 0; a < 3; a++) step(1, 1, 0, a, 36'h0, 0, 1);
        expect_done(0, 1, 3, 36'h2);
        step(1, 1, 0, 3, 36'h2, 1, 1);
        idle(6);
        do_clr("B_clr_after_t4");

        // B: counter saturation, then clear colliding with a miscompare.
        writes(36'h0);
        step(1, 1, 0, 0, 36'h1, 0, 1);
        step(1, 1, 0, 1, 36'h2, 0, 1);
        step(1, 1, 0, 2, 36'h4, 0, 1);
        step(1, 1, 0, 3, 36'h8, 0, 1);
        step(1, 1, 0, 0, 36'h10, 0, 1);
        step(1, 1, 0, 1, 36'h20, 0, 0);
        idle(2);
        do_clr("B_clr_beats_miscompare");
        // Back in IDLE: a done level without capture must not finish a test.
        ag_done = 1'b1;
        @(posedge clk); #1;
        ag_done = 1'b0;
        idle(6);
        chk("B_idle_ignores_done", 64'(b_done), 64'd0);

        // A: asynchronous reset in the middle of a check phase, then re-arm.
        sel = 1'b0;
        writes(36'h0);
        step(1, 1, 0, 0, 36'h1, 0, 1);
        step(1, 1, 0, 1, 36'h0, 0, 1);
        step(1, 1, 0, 2, 36'h0, 0, 1);
        step(1, 1, 0, 3, 36'h0, 0, 1);
        chk("A_fail_before_reset", 64'(a_fail), 64'd1);
        rst_n = 1'b0;
        #1;
        chk_zero("A_async_reset", 1'b0);
        pq_a.delete(); dq_a.delete();
        model_reset();
        @(posedge clk); #3;
        rst_n = 1'b1;
        @(posedge clk); #1;
        writes(36'h0);
        step(1, 1, 0, 2, 36'h10, 0, 1);
        expect_done(0, 1, 2, 36'h10);
        step(0, 0, 0, 0, 36'h0, 1, 0);
        idle(4);
        do_clr("A_clr_after_rearm");

        chk("A_pulse_q_drained", 64'(pq_a.size()), 64'd0);
        chk("A_done_q_drained", 64'(dq_a.size()), 64'd0);
        chk("B_pulse_q_drained", 64'(pq_b.size()), 64'd0);
        chk("B_done_q_drained", 64'(dq_b.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
